// File: rtl/booth_pkg.sv
// Shared constants and types for the radix-4 Booth partial-product accumulator.
// Holds the default multiplicand width, the row-count and product-width helpers, and the FSM states.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int num_rows(input int width);
        return width / 2;
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    function automatic int row_idx_width(input int width);
        return (width / 2 > 2) ? $clog2(width / 2) : 1;
    endfunction

    localparam int DEFAULT_NUM_ROWS   = num_rows(DEFAULT_WIDTH);
    localparam int DEFAULT_PROD_WIDTH = prod_width(DEFAULT_WIDTH);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_e;

endpackage

// File: rtl/booth_pp_align.sv
// Turns one Booth partial-product row into a product-width addend:
// sign extension from pp_e, +1 negation correction, and the 2k-bit weight shift.
module booth_pp_align
    import booth_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    localparam int NUM_ROWS = num_rows(WIDTH),
    localparam int PW       = prod_width(WIDTH),
    localparam int IDX_W    = row_idx_width(WIDTH)
) (
    input  logic [WIDTH:0]     pp_row,
    input  logic               pp_s,
    input  logic               pp_e,
    input  logic [IDX_W-1:0]   row_idx,
    output logic [PW-1:0]      addend
);

    logic [PW-1:0] row_ext;
    logic [PW-1:0] row_corr;
    logic [PW-1:0] row_shift [NUM_ROWS];

    // The head bit pp_e is the inverted sign, so extension bits are ~pp_e.
    assign row_ext  = {{(PW - WIDTH - 1){~pp_e}}, pp_row};
    assign row_corr = row_ext + {{(PW - 1){1'b0}}, pp_s};

    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_shift
            assign row_shift[gi] = row_corr << (2 * gi);
        end
    endgenerate

    always_comb begin
        addend = row_shift[0];
        for (int i = 1; i < NUM_ROWS; i++) begin
            if (row_idx == IDX_W'(i)) begin
                addend = row_shift[i];
            end
        end
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates NUM_ROWS radix-4 Booth partial-product rows into a signed 2*WIDTH-bit product.
// Define BOOTH_ACC_ERRCHK_EN to enable pp_last / head-bit protocol checking on err.
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    localparam int NUM_ROWS = num_rows(WIDTH),
    localparam int PW       = prod_width(WIDTH),
    localparam int IDX_W    = row_idx_width(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pp_valid,
    output logic            pp_ready,
    input  logic [WIDTH:0]  pp_row,
    input  logic            pp_s,
    input  logic            pp_e,
    input  logic            pp_last,
    output logic            prod_valid,
    input  logic            prod_ready,
    output logic [PW-1:0]   prod,
    output logic            err
);

    acc_state_e        state_reg;
    acc_state_e        state_next;
    logic [PW-1:0]     acc_reg;
    logic [PW-1:0]     acc_next;
    logic [IDX_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  cnt_next;
    logic              err_reg;
    logic              err_next;
    logic [PW-1:0]     addend;
    logic              row_fire;
    logic              prod_fire;
    logic              last_row;

    booth_pp_align #(
        .WIDTH   (WIDTH)
    ) u_align (
        .pp_row  (pp_row),
        .pp_s    (pp_s),
        .pp_e    (pp_e),
        .row_idx (cnt_reg),
        .addend  (addend)
    );

    assign row_fire  = pp_valid & pp_ready;
    assign prod_fire = prod_valid & prod_ready;
    assign last_row  = (cnt_reg == IDX_W'(NUM_ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    // Only the row count ends a product; pp_last never shortcuts it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACC: begin
                if (row_fire && last_row) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (prod_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_comb begin
        pp_ready   = (state_reg == ACC);
        prod_valid = (state_reg == OUT);
    end

    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        if (prod_fire) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (row_fire) begin
            acc_next = acc_reg + addend;
            if (!last_row) begin
                cnt_next = cnt_reg + IDX_W'(1);
            end
        end
    end

`ifdef BOOTH_ACC_ERRCHK_EN
    logic row_err;

    assign row_err = (pp_e == pp_row[WIDTH]) | (pp_last != last_row);

    always_comb begin
        err_next = err_reg;
        if (prod_fire) begin
            err_next = 1'b0;
        end else if (row_fire && row_err) begin
            err_next = 1'b1;
        end
    end
`else
    logic unused_pp_last;

    assign unused_pp_last = pp_last;

    always_comb begin
        err_next = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    assign prod = acc_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized Booth-product bench for booth_pp_accumulator with a row-sum reference model,
// plus directed products with literal expectations (works with or without BOOTH_ACC_ERRCHK_EN).
module tb_booth_pp_accumulator;
    import booth_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int NR = W / 2;
    localparam int PW = 2 * W;
`ifdef BOOTH_ACC_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pp_valid = 1'b0;
    logic          pp_s = 1'b0;
    logic          pp_e = 1'b0;
    logic          pp_last = 1'b0;
    logic          prod_ready = 1'b0;
    logic [W:0]    pp_row = '0;
    logic          pp_ready;
    logic          prod_valid;
    logic          err;
    logic [PW-1:0] prod;

    int total = 0;
    int bad   = 0;

    int            m_cnt = 0;
    logic [PW-1:0] m_acc = '0;
    logic          m_err = 1'b0;
    logic          m_out = 1'b0;

    logic [W:0] d_row [NR];
    logic       d_s   [NR];
    logic       d_e   [NR];
    logic       d_last[NR];
    logic [W:0] enc_row[NR];
    logic       enc_s  [NR];

    booth_pp_accumulator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pp_valid   (pp_valid),
        .pp_ready   (pp_ready),
        .pp_row     (pp_row),
        .pp_s       (pp_s),
        .pp_e       (pp_e),
        .pp_last    (pp_last),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: row k contributes (signed row, sign bit ~pp_e, plus pp_s) * 4^k.
    always @(negedge clk) begin
        longint v;
        if (!rst_n) begin
            m_cnt = 0;
            m_acc = '0;
            m_err = 1'b0;
            m_out = 1'b0;
            check("rst_prod_valid", prod_valid, 0);
            check("rst_prod", prod, 0);
            check("rst_err", err, 0);
        end else begin
            check("pp_ready", pp_ready, !m_out);
            check("prod_valid", prod_valid, m_out);
            if (m_out) begin
                check("model_prod", prod, m_acc);
                check("model_err", err, m_err);
            end
            if (!m_out && pp_valid) begin
                v = longint'(pp_row) + longint'(pp_s) - (pp_e ? 64'sd0 : (longint'(1) << (W + 1)));
                m_acc = m_acc + PW'(v * (longint'(1) << (2 * m_cnt)));
`ifdef BOOTH_ACC_ERRCHK_EN
                if (pp_e == pp_row[W]) m_err = 1'b1;
                if (pp_last != (m_cnt == NR - 1)) m_err = 1'b1;
`endif
                m_cnt++;
                if (m_cnt == NR) m_out = 1'b1;
            end else if (m_out && prod_ready) begin
                m_cnt = 0;
                m_acc = '0;
                m_err = 1'b0;
                m_out = 1'b0;
            end
        end
    end

    task automatic send_row(input logic [W:0] r, input logic s, input logic e, input logic l);
        bit ok;
        int g;
        pp_row = r; pp_s = s; pp_e = e; pp_last = l; pp_valid = 1'b1;
        ok = 1'b0;
        g = 0;
        while (!ok && g < 50) begin
            @(negedge clk);
            ok = pp_ready;
            @(posedge clk); #1;
            g++;
        end
        pp_valid = 1'b0;
        check("row_accept", ok, 1);
    endtask

    task automatic send_arr(input int n);
        for (int i = 0; i < n; i++) send_row(d_row[i], d_s[i], d_e[i], d_last[i]);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < NR; i++) begin
            d_row[i] = '0; d_s[i] = 1'b0; d_e[i] = 1'b1; d_last[i] = (i == NR - 1);
        end
    endtask

    task automatic get_prod(input int hold, input bit junk, output logic [PW-1:0] p,
                            output logic e, output int wait_cycles);
        int g;
        g = 0;
        @(negedge clk);
        while (!prod_valid && g < 100) begin
            @(posedge clk); #1;
            g++;
            @(negedge clk);
        end
        wait_cycles = g;
        p = prod;
        e = err;
        check("prod_arrives", prod_valid, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (junk) begin
                pp_valid = 1'b1; pp_row = W'($urandom); pp_s = 1'($urandom); pp_e = 1'($urandom);
            end
            @(negedge clk);
            check("hold_prod", prod, p);
            check("hold_pp_ready", pp_ready, 0);
        end
        @(posedge clk); #1;
        prod_ready = 1'b1;
        @(posedge clk); #1;
        prod_ready = 1'b0;
        pp_valid = 1'b0;
        @(negedge clk);
        check("after_prod_valid", prod_valid, 0);
        check("after_pp_ready", pp_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic encode(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] bx, ax, m;
        logic [2:0] trip;
        logic neg;
        bx = {b, 1'b0};
        ax = {a[W-1], a};
        for (int k = 0; k < NR; k++) begin
            trip = bx[2*k +: 3];
            case (trip)
                3'b001, 3'b010: begin m = ax;      neg = 1'b0; end
                3'b011:         begin m = ax << 1; neg = 1'b0; end
                3'b100:         begin m = ax << 1; neg = 1'b1; end
                3'b101, 3'b110: begin m = ax;      neg = 1'b1; end
                default:        begin m = '0;      neg = 1'b0; end
            endcase
            enc_row[k] = neg ? ~m : m;
            enc_s[k]   = neg;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] p;
        logic e;
        int wc;
        logic [W-1:0] a, b;
        logic [W-1:0] corners[6];
        bit corrupt;
        int crow;
        logic [PW-1:0] exp_p;

        corners[0] = 16'h8000; corners[1] = 16'hFFFF; corners[2] = 16'h7FFF;
        corners[3] = 16'h0000; corners[4] = 16'h0001; corners[5] = 16'h8001;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 3 * 5: rows 0-1 are +A, the rest zero.
        fill_zero(); d_row[0] = 17'h00003; d_row[1] = 17'h00003;
        send_arr(NR);
        get_prod(5, 1'b1, p, e, wc);
        check("p3x5_prod", p, 32'h0000000F);
        check("p3x5_err", e, 0);
        check("p3x5_latency", wc, 0);
        $display("directed 3x5 prod=%08h err=%0d", p, e);

        // -1 * -1
        d_row[0] = 17'h00000; d_s[0] = 1'b1; d_e[0] = 1'b1; d_last[0] = 1'b0;
        for (int i = 1; i < NR; i++) begin
            d_row[i] = 17'h1FFFF; d_s[i] = 1'b1; d_e[i] = 1'b0; d_last[i] = (i == NR - 1);
        end
        send_arr(NR);
        get_prod(0, 1'b0, p, e, wc);
        check("m1xm1_prod", p, 32'h00000001);
        check("m1xm1_latency", wc, 0);
        $display("directed -1x-1 prod=%08h err=%0d", p, e);

        // 0x8000 squared, only row 7 = -2A.
        fill_zero(); d_row[7] = 17'h0FFFF; d_s[7] = 1'b1; d_e[7] = 1'b1;
        send_arr(NR);
        get_prod(1, 1'b1, p, e, wc);
        check("min_sq_prod", p, 32'h40000000);
        check("min_sq_err", e, 0);
        $display("directed 8000^2 prod=%08h err=%0d", p, e);

        // Malformed head bit on row 2 and misplaced pp_last.
        fill_zero(); d_row[0] = 17'h00003; d_row[1] = 17'h00003;
        d_row[2] = 17'h10000; d_e[2] = 1'b1; d_last[7] = 1'b0; d_last[5] = 1'b1;
        send_arr(NR);
        get_prod(2, 1'b0, p, e, wc);
        check("proto_prod", p, 32'h0010000F);
        check("proto_err", e, ERRCHK);
        $display("directed protocol prod=%08h err=%0d", p, e);

        // Reset after three rows discards them.
        fill_zero(); d_row[0] = 17'h00003; d_row[1] = 17'h00003;
        d_row[2] = 17'h00155;
        send_arr(3);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        d_row[2] = '0;
        send_arr(NR);
        get_prod(0, 1'b0, p, e, wc);
        check("rst_mid_prod", p, 32'h0000000F);
        check("rst_mid_err", e, 0);
        $display("directed reset-mid prod=%08h err=%0d", p, e);

        for (int t = 0; t < 40; t++) begin
            if (t < 12) begin
                a = corners[t % 6]; b = corners[(t / 2) % 6];
            end else begin
                a = W'($urandom); b = W'($urandom);
            end
            encode(a, b);
            corrupt = ($urandom_range(0, 5) == 0);
            crow = $urandom_range(0, NR - 1);
            for (int k = 0; k < NR; k++) begin
                send_row(enc_row[k], enc_s[k], ~enc_row[k][W],
                         1'((k == NR - 1) ^ (corrupt && k == crow)));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) begin
                        pp_row = W'($urandom);
                        @(posedge clk); #1;
                    end
                end
            end
            get_prod($urandom_range(0, 3), 1'($urandom), p, e, wc);
            exp_p = PW'(longint'($signed(a)) * longint'($signed(b)));
            check("booth_prod", p, exp_p);
            check("booth_err", e, corrupt & ERRCHK);
            $display("product %0d a=%04h b=%04h prod=%08h err=%0d", t, a, b, p, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
